alu_nibble_sequencer: RTL and testbench

Multi-cycle controller that executes W-bit ALU operations (W = 4·NIBBLES) by sequencing a single 4-bit adder/logic slice over successive nibbles, LSB nibble first, chaining carry between cycles. Sits between a requester (start/done handshake) and one internally instantiated copy of the team's existing 4-bit `adder`, reusing it once per nibble. It produces the Z/N/C/V flags and uses the same 3-bit function encoding as the 4-bit ALU top.

---
 rtl/alu_nibble_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial ALU: runs W-bit add/sub/logic ops through one 4-bit adder slice,
// LSB nibble first, with carry chained between cycles.

module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] y,
    output logic       c_out,
    output logic       v
);
    logic [4:0] sum;

    assign sum   = {1'b0, a} + {1'b0, b} + {4'd0, c_in};
    assign y     = sum[3:0];
    assign c_out = sum[4];
    assign v     = (a[3] == b[3]) && (y[3] != a[3]);
endmodule

// state | meaning
// IDLE  | waiting for start; captures operands and func on accept
// RUN   | one nibble per enabled edge, LSB first
// DONE  | result/flags valid, done high for one enabled cycle
module alu_nibble_sequencer #(
    parameter int NIBBLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 start,
    input  logic [2:0]           func,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic [3:0]           flags
);
    localparam int W = 4 * NIBBLES;
    localparam logic [1:0] LAST_IDX = 2'(NIBBLES - 1);

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_AND = 3'b010;
    localparam logic [2:0] F_OR  = 3'b011;
    localparam logic [2:0] F_XOR = 3'b100;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_next;
    logic [1:0]     idx;
    logic           carry;
    logic [2:0]     func_q;
    logic [W-1:0]   a_sr, b_sr, r_sr;

    logic [3:0]     slice_a, slice_b, add_y, nibble;
    logic           add_c, add_v, is_arith, last;
    logic [W-1:0]   r_next;
    logic [3:0]     flags_next;

    assign slice_a  = a_sr[3:0];
    assign slice_b  = (func_q == F_SUB) ? ~b_sr[3:0] : b_sr[3:0];
    assign is_arith = (func_q == F_ADD) || (func_q == F_SUB);
    assign last     = (idx == LAST_IDX);

    adder u_adder (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry),
        .y     (add_y),
        .c_out (add_c),
        .v     (add_v)
    );

    always_comb begin
        nibble = slice_a;
        case (func_q)
            F_ADD, F_SUB: nibble = add_y;
            F_AND:        nibble = slice_a & slice_b;
            F_OR:         nibble = slice_a | slice_b;
            F_XOR:        nibble = slice_a ^ slice_b;
            default:      nibble = slice_a;
        endcase
    end

    // Shift form keeps NIBBLES=1 legal (no empty part-select).
    assign r_next     = (r_sr >> 4) | (W'(nibble) << (W - 4));
    assign flags_next = {(r_next == '0), r_next[W-1], is_arith & add_c, is_arith & add_v};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (ena)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            func_q <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            result <= '0;
            flags  <= '0;
        end else if (ena) begin
            case (state)
                IDLE: if (start) begin
                    a_sr   <= op_a;
                    b_sr   <= op_b;
                    func_q <= func;
                    idx    <= '0;
                    carry  <= (func == F_SUB);
                end
                RUN: begin
                    r_sr  <= r_next;
                    a_sr  <= a_sr >> 4;
                    b_sr  <= b_sr >> 4;
                    carry <= add_c;
                    idx   <= idx + 2'd1;
                    if (last) begin
                        result <= r_next;
                        flags  <= flags_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer (NIBBLES=2): directed vector table, random ops
// against a whole-word arithmetic model, and handshake/stall/reset sequences.
`timescale 1ns/1ps

module tb_alu_nibble_sequencer;
    localparam int N = 2;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   func = '0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int tests = 0;
    int failed = 0;

    alu_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .start  (start),
        .func   (func),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_r;
        logic [3:0]   exp_fl;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole-word reference: returns {flags, result}.
    function automatic logic [W+3:0] model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        c = 1'b0;
        v = 1'b0;
        case (f)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: r = a;
        endcase
        return {(r == '0), r[W-1], c, v, r};
    endfunction

    // One operation from IDLE; operands/func are scrambled after acceptance.
    // stall: ena held low that many cycles mid-RUN; hold: ena low while in DONE.
    task automatic do_op(input string name, input logic [2:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W+3:0] exp,
                         input int stall, input int hold);
        int lat, busy_cnt, left;
        @(negedge clk);
        start = 1'b1; func = f; op_a = a; op_b = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op_a = ~a; op_b = $urandom; func = f + 3'd3;
        lat = 0; busy_cnt = 0; left = stall;
        while (!done && lat < 30) begin
            if (busy) busy_cnt++;
            check({name, " busy_done_overlap"}, {31'd0, busy & done}, 32'd0);
            if (lat >= 1 && left > 0) begin
                ena = 1'b0;
                left--;
            end else begin
                ena = 1'b1;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ena = 1'b1;
        check({name, " latency"}, lat, 2 + stall);
        check({name, " busy_cycles"}, busy_cnt, 2 + stall);
        check({name, " result"}, {24'd0, result}, {24'd0, exp[W-1:0]});
        check({name, " flags"}, {28'd0, flags}, {28'd0, exp[W+3:W]});
        if (hold > 0) begin
            ena = 1'b0;
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
                check({name, " done_held"}, {31'd0, done}, 32'd1);
            end
            ena = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check({name, " done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{3'd0, 8'h3C, 8'h45, 8'h81, 4'b0101};
        vecs[1] = '{3'd1, 8'h10, 8'h01, 8'h0F, 4'b0010};
        vecs[2] = '{3'd1, 8'h00, 8'h01, 8'hFF, 4'b0100};
        vecs[3] = '{3'd4, 8'hA5, 8'hA5, 8'h00, 4'b1000};
        vecs[4] = '{3'd7, 8'h80, 8'h7F, 8'h80, 4'b0100};
        vecs[5] = '{3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000};

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", {24'd0, result}, 32'd0);
        check("reset flags", {28'd0, flags}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                  {vecs[i].exp_fl, vecs[i].exp_r}, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]   f;
            logic [W-1:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = W'($urandom);
            b = W'($urandom);
            do_op($sformatf("rand%0d", i), f, a, b, model(f, a, b), int'($urandom_range(0, 2)), 0);
        end

        do_op("stall3", 3'd0, 8'h3C, 8'h45, model(3'd0, 8'h3C, 8'h45), 3, 0);
        do_op("done_hold", 3'd1, 8'h00, 8'h01, model(3'd1, 8'h00, 8'h01), 0, 3);

        // Back-to-back with start held high: done every 4 cycles, one cycle wide.
        begin
            int last_k, pulses;
            last_k = -1; pulses = 0;
            @(negedge clk);
            start = 1'b1; func = 3'd0; op_a = 8'h12; op_b = 8'h34;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                if (done) begin
                    if (last_k >= 0) check("b2b period", k - last_k, 4);
                    last_k = k;
                    pulses++;
                    check("b2b result", {24'd0, result}, 32'h46);
                end
            end
            start = 1'b0;
            check("b2b pulses", pulses, 4);
            repeat (4) @(negedge clk);
        end

        // Reset one cycle after accept: outputs clear immediately, no done follows.
        do_op("pre_reset", 3'd0, 8'h3C, 8'h45, model(3'd0, 8'h3C, 8'h45), 0, 0);
        @(negedge clk);
        start = 1'b1; func = 3'd0; op_a = 8'h77; op_b = 8'h11;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("pre_reset busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async busy", {31'd0, busy}, 32'd0);
        check("async result", {24'd0, result}, 32'd0);
        check("async flags", {28'd0, flags}, 32'd0);
        check("async done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("no_done_after_abort", seen, 0);
        end
        do_op("post_reset", 3'd1, 8'h10, 8'h01, model(3'd1, 8'h10, 8'h01), 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
